mem_dma: RTL and testbench



---
 rtl/mem_dma_pkg.sv | 30 +++
 rtl/mem_dma_regs.sv | 77 +++++++
 rtl/mem_dma.sv | 178 +++++++++++++++++
 tb/tb_mem_dma.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared constants and types for the mem_dma block fill/copy engine.
// Optional feature macro: MEM_DMA_COPY_EN (copy mode).
package mem_dma_pkg;

    // Word offsets of the register window relative to BASE
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL strobe bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_ABORT = 2;

    // STATUS bit positions
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_ERR  = 1;

    // Transfer engine states; RD/W1/W2/WR only reachable when copy mode is built
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_RD   = 3'd2,
        ST_W1   = 3'd3,
        ST_W2   = 3'd4,
        ST_WR   = 3'd5
    } state_e;

endpackage

// File: rtl/mem_dma_regs.sv
// mem_dma_regs: CPU register window decode, SRC/DST/LEN storage with
// progress updates from the engine, and CTRL start/abort strobes.
// Optional feature macro: MEM_DMA_COPY_EN (no effect inside this file).
module mem_dma_regs
    import mem_dma_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hF010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_waddr,
    input  logic [15:0] cpu_wdata,
    input  logic        busy,
    input  logic        src_inc,
    input  logic        dst_inc,
    input  logic        len_dec,
    output logic [15:0] src,
    output logic [15:0] dst,
    output logic [15:0] len,
    output logic        start,
    output logic        mode,
    output logic        abort
);

    logic [15:0] off;
    logic        hit;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;

    // Window decode from CPU writes only; DMA writes never reach this path
    always_comb begin
        off   = cpu_waddr - BASE;
        hit   = cpu_wen && (off[15:2] == 14'd0);
        abort = hit && (off[1:0] == REG_CTRL) && cpu_wdata[CTRL_ABORT];
        start = hit && (off[1:0] == REG_CTRL) && cpu_wdata[CTRL_START]
                && !cpu_wdata[CTRL_ABORT];
        mode  = cpu_wdata[CTRL_MODE];
    end

    // Next register values: progress updates while busy, CPU loads only while idle
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        if (src_inc) src_d = src_q + 16'd1;
        if (dst_inc) dst_d = dst_q + 16'd1;
        if (len_dec) len_d = len_q - 16'd1;
        if (hit && !busy) begin
            case (off[1:0])
                REG_SRC: src_d = cpu_wdata;
                REG_DST: dst_d = cpu_wdata;
                REG_LEN: len_d = cpu_wdata;
                default: ;
            endcase
        end
    end

    // Register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= 16'd0;
            dst_q <= 16'd0;
            len_q <= 16'd0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
        end
    end

    assign src = src_q;
    assign dst = dst_q;
    assign len = len_q;

endmodule

// File: rtl/mem_dma.sv
// mem_dma: block fill/copy DMA engine sharing memory read port 1 and the write
// port with the CPU. The CPU always has priority; the engine only uses cycles
// the CPU leaves idle. Optional feature macro: MEM_DMA_COPY_EN builds copy mode.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hF010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ren,
    input  logic [15:0] cpu_raddr1,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_waddr,
    input  logic [15:0] cpu_wdata,
    output logic        mem_ren,
    output logic [15:0] mem_raddr1,
    output logic        mem_wen,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata1,
    output logic        busy,
    output logic [15:0] status
);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [15:0] src, dst, len;
    logic        start, mode, abort;
    logic        fill_wr, copy_rd, copy_wr, dma_wr;
    logic [15:0] dma_wdata;

`ifdef MEM_DMA_COPY_EN
    logic [15:0] data_q, data_d;
`else
    logic        unused_rdata;
    assign unused_rdata = ^mem_rdata1;
`endif

    mem_dma_regs #(.BASE(BASE)) u_regs (
        .clk       (clk),
        .rst       (rst),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .busy      (busy_q),
        .src_inc   (copy_wr),
        .dst_inc   (dma_wr),
        .len_dec   (dma_wr),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .start     (start),
        .mode      (mode),
        .abort     (abort)
    );

    // Engine memory accesses, issued only when the CPU leaves the port free
    always_comb begin
        fill_wr   = (state_q == ST_FILL) && !cpu_wen;
        copy_rd   = 1'b0;
        copy_wr   = 1'b0;
        dma_wdata = src;
`ifdef MEM_DMA_COPY_EN
        copy_rd = (state_q == ST_RD) && !cpu_ren;
        copy_wr = (state_q == ST_WR) && !cpu_wen;
        if (state_q == ST_WR) dma_wdata = data_q;
`endif
        dma_wr = fill_wr || copy_wr;
    end

    // Port arbiter: CPU passes through unless the engine owns a free cycle.
    // mem_ren follows the CPU only, so engine reads never pop the PS/2 FIFO.
    always_comb begin
        mem_ren    = cpu_ren;
        mem_raddr1 = copy_rd ? src : cpu_raddr1;
        mem_wen    = cpu_wen || dma_wr;
        mem_waddr  = dma_wr ? dst : cpu_waddr;
        mem_wdata  = dma_wr ? dma_wdata : cpu_wdata;
    end

    // Next-state logic; abort overrides everything and keeps register progress
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        err_d   = err_q;
`ifdef MEM_DMA_COPY_EN
        data_d  = data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode) begin
`ifdef MEM_DMA_COPY_EN
                        err_d = 1'b0;
                        if (len != 16'd0) begin
                            state_d = ST_RD;
                            busy_d  = 1'b1;
                        end
`else
                        err_d = 1'b1;
`endif
                    end else begin
                        err_d = 1'b0;
                        if (len != 16'd0) begin
                            state_d = ST_FILL;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end
            ST_FILL: begin
                if (fill_wr && (len == 16'd1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
`ifdef MEM_DMA_COPY_EN
            ST_RD: begin
                if (copy_rd) state_d = ST_W1;
            end
            ST_W1: state_d = ST_W2;
            ST_W2: begin
                data_d  = mem_rdata1;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (copy_wr) begin
                    if (len == 16'd1) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_DMA_COPY_EN
            data_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef MEM_DMA_COPY_EN
            data_q  <= data_d;
`endif
        end
    end

    // Status word seen by CPU reads of BASE+3
    always_comb begin
        status              = 16'd0;
        status[STATUS_BUSY] = busy_q;
        status[STATUS_ERR]  = err_q;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed and randomized checks of mem_dma fill/copy transfers,
// CPU priority stalls, address wrap, abort, reset and start rejection.
// Optional feature macro: MEM_DMA_COPY_EN selects the copy-mode tests.
module tb_mem_dma;

    localparam logic [15:0] BASE   = 16'hF010;
    localparam logic [1:0]  O_SRC  = 2'd0;
    localparam logic [1:0]  O_DST  = 2'd1;
    localparam logic [1:0]  O_LEN  = 2'd2;
    localparam logic [1:0]  O_CTRL = 2'd3;
`ifdef MEM_DMA_COPY_EN
    localparam bit HAS_COPY = 1'b1;
`else
    localparam bit HAS_COPY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ren, cpu_wen;
    logic [15:0] cpu_raddr1, cpu_waddr, cpu_wdata;
    logic        mem_ren, mem_wen;
    logic [15:0] mem_raddr1, mem_waddr, mem_wdata;
    logic [15:0] mem_rdata1 = 16'd0;
    logic        busy;
    logic [15:0] status;

    logic [15:0] mem [0:65535];
    logic [15:0] rd_pipe = 16'd0;
    int          total = 0;
    int          bad = 0;
    int          ren_bad = 0;
    int          rd_bad = 0;
    int          wr_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    mem_dma #(.BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ren    (cpu_ren),
        .cpu_raddr1 (cpu_raddr1),
        .cpu_wen    (cpu_wen),
        .cpu_waddr  (cpu_waddr),
        .cpu_wdata  (cpu_wdata),
        .mem_ren    (mem_ren),
        .mem_raddr1 (mem_raddr1),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_rdata1 (mem_rdata1),
        .busy       (busy),
        .status     (status)
    );

    // clock
    always #5 clk = ~clk;

    // memory: 2-cycle read latency, IO range F000..FFFF ignores writes
    always @(posedge clk) begin
        mem_rdata1 <= mem[rd_pipe];
        rd_pipe    <= mem_raddr1;
        if (mem_wen === 1'b1 && mem_waddr < 16'hF000) mem[mem_waddr] = mem_wdata;
    end

    // port monitor: CPU accesses pass untouched, engine writes are logged
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_ren !== cpu_ren) ren_bad++;
            if (cpu_ren && mem_raddr1 !== cpu_raddr1) rd_bad++;
            if (cpu_wen && (mem_wen !== 1'b1 || mem_waddr !== cpu_waddr || mem_wdata !== cpu_wdata))
                wr_bad++;
            if (!cpu_wen && mem_wen === 1'b1) obs_q.push_back({mem_waddr, mem_wdata});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] o, input logic [15:0] d);
        cpu_wen   = 1'b1;
        cpu_waddr = BASE + {14'd0, o};
        cpu_wdata = d;
        tick();
        cpu_wen   = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] n, input logic [15:0] ctrl);
        reg_wr(O_SRC, s);
        reg_wr(O_DST, d);
        reg_wr(O_LEN, n);
        reg_wr(O_CTRL, ctrl);
    endtask

    // Drive CPU contention from masks (bit k = busy cycle k+1) until busy drops
    task automatic run(input logic [127:0] wm, input logic [127:0] rm, output int cyc,
                       output bit had_w, output logic [15:0] la, output logic [15:0] ld);
        cyc   = 0;
        had_w = 1'b0;
        la    = 16'd0;
        ld    = 16'd0;
        while (busy === 1'b1 && cyc < 400) begin
            cpu_wen    = (cyc < 128) ? wm[cyc] : 1'b0;
            cpu_waddr  = 16'h0100 + 16'(cyc);
            cpu_wdata  = 16'hA500 + 16'(cyc);
            cpu_ren    = (cyc < 128) ? rm[cyc] : 1'b0;
            cpu_raddr1 = 16'h0200 + 16'(cyc);
            if (cpu_wen) begin
                had_w = 1'b1;
                la    = cpu_waddr;
                ld    = cpu_wdata;
            end
            cyc++;
            tick();
        end
        cpu_wen = 1'b0;
        cpu_ren = 1'b0;
    endtask

    function automatic logic [127:0] rand_mask(input int one_in);
        logic [127:0] m = '0;
        for (int k = 0; k < 128; k++) m[k] = ($urandom_range(0, one_in - 1) == 0);
        return m;
    endfunction

    // Reference timing: each fill word needs one free write cycle
    function automatic int fill_cycles(input int n, input logic [127:0] wm);
        int k = 0;
        int w = 0;
        while (w < n) begin
            if (!(k < 128 && wm[k])) w++;
            k++;
        end
        return k;
    endfunction

    // Reference timing: free read cycle, two fixed latency cycles, free write cycle
    function automatic int copy_cycles(input int n, input logic [127:0] wm, input logic [127:0] rm);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            while (k < 128 && rm[k]) k++;
            k += 3;
            while (k < 128 && wm[k]) k++;
            k++;
        end
        return k;
    endfunction

    task automatic push_fill(input logic [15:0] v, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({d + 16'(i), v});
    endtask

    task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({d + 16'(i), mem[s + 16'(i)]});
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_write"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          cyc, n;
        bit          hw;
        logic [15:0] la, ld, v, d, s;
        logic [127:0] wm, rm;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        rst = 1'b1;
        cpu_ren = 1'b0; cpu_wen = 1'b0;
        cpu_raddr1 = 16'h1234; cpu_waddr = 16'h5678; cpu_wdata = 16'h9ABC;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // reset state and idle pass-through
        chk("rst_busy", busy, 1'b0);
        chk("rst_status", status, 16'h0000);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_mem_ren", mem_ren, 1'b0);
        chk("rst_raddr", mem_raddr1, 16'h1234);
        chk("rst_waddr", mem_waddr, 16'h5678);
        chk("rst_wdata", mem_wdata, 16'h9ABC);
        tick();

        // directed fill, no contention
        start_xfer(16'h00AA, 16'hE000, 16'd4, 16'h0001);
        chk("fill_busy_on", busy, 1'b1);
        chk("fill_status_busy", status, 16'h0001);
        run('0, '0, cyc, hw, la, ld);
        chk("fill_cycles", cyc, 4);
        push_fill(16'h00AA, 16'hE000, 4);
        check_writes("fill");
        chk("fill_status_idle", status, 16'h0000);

        // random fills with random CPU write contention
        for (int t = 0; t < 4; t++) begin
            v  = 16'($urandom);
            d  = 16'hE100 + 16'(t * 16);
            n  = $urandom_range(1, 12);
            wm = rand_mask(4);
            start_xfer(v, d, 16'(n), 16'h0001);
            run(wm, '0, cyc, hw, la, ld);
            chk("rfill_cycles", cyc, fill_cycles(n, wm));
            push_fill(v, d, n);
            check_writes("rfill");
            if (hw) chk("rfill_cpu_write", mem[la], ld);
        end

        // register writes and start while busy are ignored but still stall
        start_xfer(16'h7777, 16'hE300, 16'd6, 16'h0001);
        tick();
        tick();
        reg_wr(O_DST, 16'h0050);
        reg_wr(O_CTRL, 16'h0001);
        run('0, '0, cyc, hw, la, ld);
        chk("ign_cycles", cyc, 4);
        push_fill(16'h7777, 16'hE300, 6);
        check_writes("ign");

        // destination wrap 0xFFFF -> 0x0000
        start_xfer(16'h1234, 16'hFFFF, 16'd2, 16'h0001);
        run('0, '0, cyc, hw, la, ld);
        chk("wrap_cycles", cyc, 2);
        exp_q.push_back({16'hFFFF, 16'h1234});
        exp_q.push_back({16'h0000, 16'h1234});
        check_writes("wrap");

        // abort after 10 words, then resume from the kept progress
        start_xfer(16'h3C3C, 16'hE600, 16'd100, 16'h0001);
        repeat (10) tick();
        reg_wr(O_CTRL, 16'h0005);
        chk("abort_busy", busy, 1'b0);
        repeat (5) tick();
        push_fill(16'h3C3C, 16'hE600, 10);
        check_writes("abort");
        reg_wr(O_CTRL, 16'h0005);
        chk("abort_wins", busy, 1'b0);
        reg_wr(O_CTRL, 16'h0001);
        chk("resume_busy", busy, 1'b1);
        run('0, '0, cyc, hw, la, ld);
        chk("resume_cycles", cyc, 90);
        push_fill(16'h3C3C, 16'hE60A, 90);
        check_writes("resume");

`ifdef MEM_DMA_COPY_EN
        // directed copy with one CPU write in the first WR cycle
        mem[16'hC000] = 16'd1; mem[16'hC001] = 16'd2; mem[16'hC002] = 16'd3;
        wm = '0;
        wm[3] = 1'b1;
        push_copy(16'hC000, 16'hE010, 3);
        start_xfer(16'hC000, 16'hE010, 16'd3, 16'h0003);
        chk("copy_busy_on", busy, 1'b1);
        run(wm, '0, cyc, hw, la, ld);
        chk("copy_cycles", cyc, 13);
        check_writes("copy");
        chk("copy_cpu_write", mem[16'h0103], 16'hA503);
        chk("copy_dst2", mem[16'hE012], 16'd3);

        // CPU reads hold the second word's read for 3 cycles
        rm = '0;
        rm[4] = 1'b1; rm[5] = 1'b1; rm[6] = 1'b1;
        push_copy(16'hC100, 16'hE020, 2);
        start_xfer(16'hC100, 16'hE020, 16'd2, 16'h0003);
        run('0, rm, cyc, hw, la, ld);
        chk("rdcont_cycles", cyc, 11);
        check_writes("rdcont");

        // random copies with random read and write contention
        for (int t = 0; t < 3; t++) begin
            s  = 16'hC200 + 16'(t * 32);
            d  = 16'hE800 + 16'(t * 32);
            n  = $urandom_range(1, 5);
            wm = rand_mask(3);
            rm = rand_mask(3);
            push_copy(s, d, n);
            start_xfer(s, d, 16'(n), 16'h0003);
            run(wm, rm, cyc, hw, la, ld);
            chk("rcopy_cycles", cyc, copy_cycles(n, wm, rm));
            check_writes("rcopy");
        end

        // copy out of the IO range must not raise mem_ren
        push_copy(16'hF000, 16'hE040, 2);
        start_xfer(16'hF000, 16'hE040, 16'd2, 16'h0003);
        run('0, '0, cyc, hw, la, ld);
        chk("io_cycles", cyc, 8);
        check_writes("io");
        chk("copy_err_clear", status, 16'h0000);
`else
        // copy start rejected when copy mode is not built
        start_xfer(16'h5555, 16'hE400, 16'd3, 16'h0003);
        chk("rej_busy", busy, 1'b0);
        chk("rej_status", status, 16'h0002);
        repeat (3) tick();
        check_writes("rej");
        reg_wr(O_CTRL, 16'h0001);
        chk("rej_fill_status", status, 16'h0001);
        run('0, '0, cyc, hw, la, ld);
        chk("rej_fill_cycles", cyc, 3);
        push_fill(16'h5555, 16'hE400, 3);
        check_writes("rej_fill");
        chk("rej_status_end", status, 16'h0000);
`endif

        // asynchronous reset in the middle of a transfer
        start_xfer(HAS_COPY ? 16'hC000 : 16'h4242, 16'hE500, 16'd8, HAS_COPY ? 16'h0003 : 16'h0001);
        chk("rstmid_busy_on", busy, 1'b1);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_status", status, 16'h0000);
        chk("rstmid_mem_wen", mem_wen, 1'b0);
        obs_q.delete();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        reg_wr(O_CTRL, 16'h0001);
        chk("len0_busy", busy, 1'b0);
        repeat (3) tick();
        check_writes("rstmid");

        chk("pass_ren", ren_bad, 0);
        chk("pass_raddr", rd_bad, 0);
        chk("pass_write", wr_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
